// File: rtl/load_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : load_ramp_ctrl
// Brief    : Thermometer-code ramp sequencer for a toggle-load block array,
//            with optional on/off pulse gating once the target is reached.
// Revision : 1.0 - initial release
// ============================================================================
module load_ramp_ctrl #(
    parameter int NUM_BLOCKS = 16,
    parameter int STEP_W     = 16,
    parameter int PER_W      = 24,
    localparam int LW        = $clog2(NUM_BLOCKS + 1)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [LW-1:0]         CMD_LEVEL,
    input  logic [STEP_W-1:0]     CMD_STEP,
    input  logic [PER_W-1:0]      CMD_ON_CYCLES,
    input  logic [PER_W-1:0]      CMD_OFF_CYCLES,
    output logic [NUM_BLOCKS-1:0] BLOCK_EN,
    output logic [LW-1:0]         LEVEL,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam logic [LW-1:0]     c_MAX_LEVEL = LW'(NUM_BLOCKS);
    localparam logic [STEP_W-1:0] c_STEP_ONE  = STEP_W'(1);
    localparam logic [PER_W-1:0]  c_PER_ONE   = PER_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RAMP = 1'b1
    } state_t;

    state_t                r_state,     w_state_nxt;
    logic [LW-1:0]         r_level,     w_level_nxt;
    logic [LW-1:0]         r_target,    w_target_nxt;
    logic [STEP_W-1:0]     r_step,      w_step_nxt;
    logic [STEP_W-1:0]     r_step_cnt,  w_step_cnt_nxt;
    logic [PER_W-1:0]      r_on,        w_on_nxt;
    logic [PER_W-1:0]      r_off,       w_off_nxt;
    logic [PER_W-1:0]      r_phase_cnt, w_phase_cnt_nxt;
    logic                  r_gate,      w_gate_nxt;
    logic                  r_done,      w_done_nxt;
    logic                  r_busy;
    logic                  r_ready;
    logic [NUM_BLOCKS-1:0] r_block_en;

    logic [LW-1:0]         w_cmd_target;
    logic [STEP_W-1:0]     w_cmd_step;
    logic                  w_pulse_en;
    logic [LW-1:0]         w_level_step;

    function automatic logic [NUM_BLOCKS-1:0] f_therm(input logic [LW-1:0] lvl);
        logic [NUM_BLOCKS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            v[i] = (i < int'(lvl));
        end
        return v;
    endfunction

    assign w_cmd_target = (CMD_LEVEL > c_MAX_LEVEL) ? c_MAX_LEVEL : CMD_LEVEL;
    assign w_cmd_step   = (CMD_STEP == '0) ? c_STEP_ONE : CMD_STEP;
    assign w_pulse_en   = (r_on != '0) && (r_off != '0);
    assign w_level_step = (r_target > r_level) ? (r_level + LW'(1)) : (r_level - LW'(1));

    always_comb begin
        w_state_nxt     = r_state;
        w_level_nxt     = r_level;
        w_target_nxt    = r_target;
        w_step_nxt      = r_step;
        w_step_cnt_nxt  = r_step_cnt;
        w_on_nxt        = r_on;
        w_off_nxt       = r_off;
        w_phase_cnt_nxt = r_phase_cnt;
        w_gate_nxt      = r_gate;
        w_done_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (CMD_VALID) begin
                    w_target_nxt    = w_cmd_target;
                    w_step_nxt      = w_cmd_step;
                    w_on_nxt        = CMD_ON_CYCLES;
                    w_off_nxt       = CMD_OFF_CYCLES;
                    w_gate_nxt      = 1'b1;
                    w_phase_cnt_nxt = '0;
                    w_step_cnt_nxt  = '0;
                    if (w_cmd_target == r_level) begin
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_RAMP;
                    end
                end else if (w_pulse_en) begin
                    // Phase counter measures time spent in the current half-period.
                    if (r_gate) begin
                        if (r_phase_cnt == r_on - c_PER_ONE) begin
                            w_gate_nxt      = 1'b0;
                            w_phase_cnt_nxt = '0;
                        end else begin
                            w_phase_cnt_nxt = r_phase_cnt + c_PER_ONE;
                        end
                    end else begin
                        if (r_phase_cnt == r_off - c_PER_ONE) begin
                            w_gate_nxt      = 1'b1;
                            w_phase_cnt_nxt = '0;
                        end else begin
                            w_phase_cnt_nxt = r_phase_cnt + c_PER_ONE;
                        end
                    end
                end else begin
                    w_gate_nxt = 1'b1;
                end
            end

            S_RAMP: begin
                w_gate_nxt = 1'b1;
                if (r_step_cnt == r_step - c_STEP_ONE) begin
                    w_step_cnt_nxt = '0;
                    w_level_nxt    = w_level_step;
                    if (w_level_step == r_target) begin
                        w_state_nxt     = S_IDLE;
                        w_done_nxt      = 1'b1;
                        w_phase_cnt_nxt = '0;
                    end
                end else begin
                    w_step_cnt_nxt = r_step_cnt + c_STEP_ONE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_level     <= '0;
            r_target    <= '0;
            r_step      <= '0;
            r_step_cnt  <= '0;
            r_on        <= '0;
            r_off       <= '0;
            r_phase_cnt <= '0;
            r_gate      <= 1'b1;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
            r_block_en  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_level     <= w_level_nxt;
            r_target    <= w_target_nxt;
            r_step      <= w_step_nxt;
            r_step_cnt  <= w_step_cnt_nxt;
            r_on        <= w_on_nxt;
            r_off       <= w_off_nxt;
            r_phase_cnt <= w_phase_cnt_nxt;
            r_gate      <= w_gate_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= (w_state_nxt == S_RAMP);
            r_ready     <= (w_state_nxt == S_IDLE);
            r_block_en  <= w_gate_nxt ? f_therm(w_level_nxt) : '0;
        end
    end

    assign CMD_READY = r_ready;
    assign BLOCK_EN  = r_block_en;
    assign LEVEL     = r_level;
    assign BUSY      = r_busy;
    assign DONE      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_load_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_ramp_ctrl
// Brief    : Table-driven scoreboard bench for load_ramp_ctrl (NUM_BLOCKS=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_ramp_ctrl;

    logic        CLK;
    logic        RESET;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [4:0]  CMD_LEVEL;
    logic [15:0] CMD_STEP;
    logic [23:0] CMD_ON_CYCLES;
    logic [23:0] CMD_OFF_CYCLES;
    logic [15:0] BLOCK_EN;
    logic [4:0]  LEVEL;
    logic        BUSY;
    logic        DONE;

    load_ramp_ctrl #(
        .NUM_BLOCKS (16),
        .STEP_W     (16),
        .PER_W      (24)
    ) u_dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .CMD_VALID      (CMD_VALID),
        .CMD_READY      (CMD_READY),
        .CMD_LEVEL      (CMD_LEVEL),
        .CMD_STEP       (CMD_STEP),
        .CMD_ON_CYCLES  (CMD_ON_CYCLES),
        .CMD_OFF_CYCLES (CMD_OFF_CYCLES),
        .BLOCK_EN       (BLOCK_EN),
        .LEVEL          (LEVEL),
        .BUSY           (BUSY),
        .DONE           (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [4:0]  lvl;
        logic [15:0] stp;
        logic [23:0] on_c;
        logic [23:0] off_c;
        logic [4:0]  e_lvl;
        logic [15:0] e_en;
        logic        e_busy;
        logic        e_done;
        logic        e_ready;
    } vec_t;

    typedef struct packed {
        logic [4:0]  lvl;
        logic [15:0] en;
        logic        busy;
        logic        done;
        logic        ready;
    } obs_t;

    vec_t tbl[$];
    obs_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [15:0] therm(input int n);
        logic [16:0] t;
        t = (17'd1 << n) - 17'd1;
        return t[15:0];
    endfunction

    function automatic vec_t mk(input int rst, input int valid, input int lvl, input int stp,
                                input int on_c, input int off_c, input int e_lvl, input int e_en,
                                input int e_busy, input int e_done, input int e_ready);
        vec_t v;
        v.rst = 1'(rst);       v.valid = 1'(valid);    v.lvl = 5'(lvl);
        v.stp = 16'(stp);      v.on_c = 24'(on_c);     v.off_c = 24'(off_c);
        v.e_lvl = 5'(e_lvl);   v.e_en = 16'(e_en);     v.e_busy = 1'(e_busy);
        v.e_done = 1'(e_done); v.e_ready = 1'(e_ready);
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic apply(input vec_t v, input string tag);
        obs_t got;
        obs_t exp;
        RESET          = v.rst;
        CMD_VALID      = v.valid;
        CMD_LEVEL      = v.lvl;
        CMD_STEP       = v.stp;
        CMD_ON_CYCLES  = v.on_c;
        CMD_OFF_CYCLES = v.off_c;
        sb_q.push_back('{v.e_lvl, v.e_en, v.e_busy, v.e_done, v.e_ready});
        @(posedge CLK);
        #1;
        got = '{LEVEL, BLOCK_EN, BUSY, DONE, CMD_READY};
        exp = sb_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got lvl=%0d en=%h busy=%b done=%b rdy=%b, want lvl=%0d en=%h busy=%b done=%b rdy=%b",
                     tag, got.lvl, got.en, got.busy, got.done, got.ready,
                     exp.lvl, exp.en, exp.busy, exp.done, exp.ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lv;
        RESET = 1'b1; CMD_VALID = 1'b0; CMD_LEVEL = '0; CMD_STEP = '0;
        CMD_ON_CYCLES = '0; CMD_OFF_CYCLES = '0;

        // Reset held 3 cycles with a command pending; accepted on the first free edge.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 4, 3, 0, 0, 0, 0, 0, 0, 1));
        for (int e = 0; e <= 13; e++) begin
            lv = (e / 3 > 4) ? 4 : e / 3;
            tbl.push_back(mk(0, (e == 0), 4, 3, 0, 0, lv, therm(lv), (e < 12), (e == 12), (e >= 12)));
        end
        // Ramp down, STEP=0 treated as 1, mid-ramp command ignored.
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 4, 16'h000F, 1, 0, 0));
        tbl.push_back(mk(0, 1, 9, 5, 0, 0, 3, 16'h0007, 1, 0, 0));
        tbl.push_back(mk(0, 0, 9, 5, 0, 0, 2, 16'h0003, 1, 0, 0));
        tbl.push_back(mk(0, 0, 9, 5, 0, 0, 1, 16'h0001, 0, 1, 1));
        tbl.push_back(mk(0, 0, 9, 5, 0, 0, 1, 16'h0001, 0, 0, 1));
        // Clamp 20 -> 16, then a no-op command at the same level.
        tbl.push_back(mk(0, 1, 20, 0, 0, 0, 1, 16'h0001, 1, 0, 0));
        for (int k = 1; k <= 15; k++)
            tbl.push_back(mk(0, 0, 20, 0, 0, 0, 1 + k, therm(1 + k), (k < 15), (k == 15), (k == 15)));
        tbl.push_back(mk(0, 1, 16, 2, 0, 0, 16, 16'hFFFF, 0, 1, 1));
        tbl.push_back(mk(0, 0, 16, 2, 0, 0, 16, 16'hFFFF, 0, 0, 1));
        // Ramp to 8 then pulse 5 on / 3 off.
        tbl.push_back(mk(0, 1, 8, 1, 5, 3, 16, 16'hFFFF, 1, 0, 0));
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(0, 0, 8, 1, 5, 3, 16 - k, therm(16 - k), (k < 8), (k == 8), (k == 8)));
        for (int m = 1; m <= 37; m++)
            tbl.push_back(mk(0, 0, 8, 1, 5, 3, 8, ((m % 8) < 5) ? 16'h00FF : 16'h0000, 0, 0, 1));
        // New command during the off phase restores the enables immediately.
        tbl.push_back(mk(0, 1, 12, 2, 0, 0, 8, 16'h00FF, 1, 0, 0));
        tbl.push_back(mk(0, 0, 12, 2, 0, 0, 8, 16'h00FF, 1, 0, 0));
        tbl.push_back(mk(1, 0, 12, 2, 0, 0, 0, 16'h0000, 0, 0, 1));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of a 0 -> 12 ramp at LEVEL=6.
        apply(mk(0, 1, 12, 2, 0, 0, 0, 0, 1, 0, 0), "mid_accept");
        for (int e = 1; e <= 12; e++)
            apply(mk(0, 0, 12, 2, 0, 0, e / 2, therm(e / 2), 1, 0, 0), $sformatf("mid_ramp%0d", e));
        apply(mk(1, 1, 12, 2, 0, 0, 0, 0, 0, 0, 1), "mid_reset");
        apply(mk(0, 0, 12, 2, 0, 0, 0, 0, 0, 0, 1), "mid_after");

        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
